// File: rtl/fpu_pkg.sv
// Shared FPU constants and stage bundles.
// Used by the converters and the normalisers.
package fpu_pkg;

  localparam int FP_BIAS  = 127;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  localparam logic [31:0] FP_ZERO = 32'h0;
  localparam logic [FP_EXP_W-1:0] I2F_EXP_BASE =
    FP_EXP_W'(FP_BIAS + 31);

  typedef struct packed {
    logic        sign;
    logic [31:0] mag;
  } i2f_s1_t;

  // norm drops the implicit leading one
  typedef struct packed {
    logic                sign;
    logic                zero;
    logic [FP_EXP_W-1:0] exp;
    logic [30:0]         norm;
  } i2f_s2_t;

endpackage

// File: rtl/lzc32.sv
// 32-bit leading-zero counter.
// cnt is 0 when the input is all zero.
module lzc32 (
  input  logic [31:0] a,
  output logic [4:0]  cnt,
  output logic        all_zero
);

  always_comb begin
    cnt = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (a[i]) cnt = 5'(31 - i);
    end
  end

  assign all_zero = (a == 32'h0);

endmodule

// File: rtl/itof_pipe.sv
// Pipelined signed int32 to IEEE-754 single.
// Three stages: magnitude, normalise, round/pack.
module itof_pipe
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag
);

  logic v1, v2;
  logic en1, en2, en3;
  i2f_s1_t r1, s1_d;
  i2f_s2_t r2, s2_d;
  logic [TAG_W-1:0] t1, t2;
  logic [4:0] lz;
  logic z;

  logic [FP_MAN_W-1:0] m;
  logic                up;
  logic [FP_MAN_W:0]   sum;
  logic [FP_EXP_W-1:0] e;
  logic [31:0]         packed_res;

  assign en3 = !out_valid | out_ready;
  assign en2 = !v2 | en3;
  assign en1 = !v1 | en2;
  assign in_ready = en1;

  always_comb begin
    s1_d.sign = in_data[31];
    s1_d.mag  = in_data[31] ? (~in_data + 32'd1)
                            : in_data;
  end

  lzc32 u_lzc (
    .a        (r1.mag),
    .cnt      (lz),
    .all_zero (z)
  );

  always_comb begin
    s2_d.sign = r1.sign;
    s2_d.zero = z;
    s2_d.exp  = I2F_EXP_BASE - {3'b0, lz};
    s2_d.norm = 31'(r1.mag << lz);
  end

  // round to nearest, ties to even
  always_comb begin
    m   = r2.norm[30:8];
    up  = r2.norm[7] & ((|r2.norm[6:0]) | m[0]);
    sum = {1'b0, m} + {{FP_MAN_W{1'b0}}, up};
    e   = r2.exp + {{(FP_EXP_W-1){1'b0}}, sum[FP_MAN_W]};
    packed_res = r2.zero ? FP_ZERO
               : {r2.sign, e, sum[FP_MAN_W-1:0]};
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (en1) v1 <= in_valid;
      if (en2) v2 <= v1;
      if (en3) out_valid <= v2;
    end
  end

  always_ff @(posedge clk) begin
    if (en1) begin
      r1 <= s1_d;
      t1 <= in_tag;
    end
    if (en2) begin
      r2 <= s2_d;
      t2 <= t1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= FP_ZERO;
      out_tag  <= '0;
    end else if (en3) begin
      out_data <= packed_res;
      out_tag  <= t2;
    end
  end

endmodule

// File: tb/tb_itof_pipe.sv
// Directed self-checking bench for itof_pipe.
// Expected floats are hand-computed constants.
module tb_itof_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  itof_pipe #(.TAG_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  task automatic convert(input logic [31:0] d,
                         input logic [4:0]  t,
                         input logic [31:0] expv,
                         input string       name);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_tag = t;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (out_valid !== 1'b1 || out_data !== expv ||
        out_tag !== t || n != 3) begin
      fails++;
      $display("FAIL %s: got %h tag %0d lat %0d v %b, want %h tag %0d lat 3",
               name, out_data, out_tag, n, out_valid, expv, t);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 ||
        out_tag !== 5'd0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset: v %b d %h t %0d rdy %b, want 0 0 0 1",
               out_valid, out_data, out_tag, in_ready);
    end
  endtask

  task automatic test_basic();
    convert(32'h00000001, 5'd3, 32'h3F800000, "one");
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL pulse: out_valid %b, want 0", out_valid);
    end
    convert(32'hFFFFFFFF, 5'd4, 32'hBF800000, "minus_one");
    convert(32'h00000000, 5'd5, 32'h00000000, "zero");
    convert(32'h00000064, 5'd6, 32'h42C80000, "hundred");
  endtask

  task automatic test_rounding();
    convert(32'h01000001, 5'd7, 32'h4B800000, "tie_down");
    convert(32'h01000003, 5'd8, 32'h4B800002, "tie_up");
    convert(32'h7FFFFFFF, 5'd9, 32'h4F000000, "carry");
    convert(32'h80000000, 5'd10, 32'hCF000000, "int_min");
  endtask

  task automatic test_back_to_back();
    logic [31:0] vin [8];
    logic [31:0] vexp [8];
    logic [31:0] held;
    logic        was_stall;
    int idx, oidx;
    vin  = '{32'd1, 32'd2, 32'd3, 32'hFFFFFFFF,
             32'd100, 32'd0, 32'h7FFFFFFF, 32'h80000000};
    vexp = '{32'h3F800000, 32'h40000000, 32'h40400000,
             32'hBF800000, 32'h42C80000, 32'h00000000,
             32'h4F000000, 32'hCF000000};
    idx = 0; oidx = 0; was_stall = 1'b0; held = '0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 2 && c <= 6);
      in_valid  = (idx < 8);
      in_data   = (idx < 8) ? vin[idx] : 32'h0;
      in_tag    = 5'(idx);
      #1;
      if (c == 3) begin
        tests++;
        if (idx != 3 || in_ready !== 1'b0) begin
          fails++;
          $display("FAIL b2b_fill: accepted %0d rdy %b, want 3 0",
                   idx, in_ready);
        end
      end
      if (was_stall && out_valid) begin
        tests++;
        if (out_data !== held) begin
          fails++;
          $display("FAIL b2b_hold: got %h, want %h", out_data, held);
        end
      end
      was_stall = out_valid && !out_ready;
      held = out_data;
      if (out_valid && out_ready) begin
        tests++;
        if (oidx >= 8 || out_data !== vexp[oidx % 8] ||
            out_tag !== 5'(oidx)) begin
          fails++;
          $display("FAIL b2b_out%0d: got %h tag %0d, want %h tag %0d",
                   oidx, out_data, out_tag, vexp[oidx % 8], oidx);
        end
        oidx++;
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0;
    tests++;
    if (oidx != 8 || idx != 8) begin
      fails++;
      $display("FAIL b2b_count: in %0d out %0d, want 8 8", idx, oidx);
    end
  endtask

  task automatic test_flush();
    int seen;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 32'(k + 5); in_tag = 5'(k);
    end
    @(posedge clk); #1;
    flush = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'd9; in_tag = 5'd20;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL flush: out_valid seen %0d, want 0", seen);
    end
    convert(32'h00000064, 5'd11, 32'h42C80000, "post_flush");
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 32'd3; in_tag = 5'd1;
    @(posedge clk); #1;
    in_data = 32'd2; in_tag = 5'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 ||
        out_tag !== 5'd0) begin
      fails++;
      $display("FAIL mid_reset: v %b d %h t %0d, want 0 0 0",
               out_valid, out_data, out_tag);
    end
    convert(32'hFFFFFFFF, 5'd12, 32'hBF800000, "post_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_back_to_back();
    test_flush();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
